// File: rtl/sd_stream_ctrl_pkg.sv
// Shared definitions for the SD read-side streaming controller.
// Holds the FSM encoding and the SD sector geometry.
package sd_stream_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_ROOM = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_HI   = 3'd3;
  localparam logic [2:0] ST_WAIT_LO   = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Sector geometry, also used by the SD write-side sequencer.
  localparam int SD_SEC_BYTES = 512;
  localparam int SD_SEC_WORDS = SD_SEC_BYTES / 2;

endpackage

// File: rtl/sd_stream_ctrl.sv
// Multi-sector SD read scheduler: issues one sector read at a time when the FIFO has a sector of room.
// Read words reach the FIFO one cycle later; backpressure is the room check before each read.
module sd_stream_ctrl
  import sd_stream_ctrl_pkg::*;
#(
  parameter int SEC_WORDS = SD_SEC_WORDS,
  parameter int FIFO_AW   = 10,
  parameter int BUSY_TMO  = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sd_init_done,
  input  logic               play_start,
  input  logic               play_stop,
  input  logic [32:0]        start_sec,
  input  logic [31:0]        sec_num,
  input  logic               rd_busy,
  input  logic               rd_val_en,
  input  logic [15:0]        rd_val_data,
  output logic               rd_start_en,
  output logic [32:0]        rd_sec_addr,
  input  logic               fifo_full,
  input  logic [FIFO_AW-1:0] fifo_wrusedw,
  output logic               fifo_wr_en,
  output logic [15:0]        fifo_wr_data,
  output logic               stream_busy,
  output logic               stream_done,
  output logic [31:0]        sec_left,
  output logic               error_flag
);

  localparam int WCW = $clog2(SEC_WORDS + 2);
  localparam int TCW = $clog2(BUSY_TMO + 1);
  localparam logic [FIFO_AW:0] FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  logic [2:0]       state;
  logic             stop_pend;
  logic             rd_busy_d0;
  logic [WCW-1:0]   word_cnt;
  logic [TCW-1:0]   tmo_cnt;
  logic [FIFO_AW:0] room;
  logic             room_ok;
  logic             in_read;
  logic             busy_fall;
  logic             stop_req;
  logic             start_ok;

  // usedw wraps to zero when the FIFO is full, so full must override it.
  always_comb begin
    room = '0;
    if (!fifo_full) begin
      room = FIFO_DEPTH - {1'b0, fifo_wrusedw};
    end
  end

  assign room_ok     = int'(room) >= SEC_WORDS;
  assign in_read     = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
  assign busy_fall   = rd_busy_d0 && !rd_busy;
  assign stop_req    = stop_pend || play_stop;
  assign start_ok    = play_start && sd_init_done;
  assign stream_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy_d0 <= 1'b0;
    end else begin
      rd_busy_d0 <= rd_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= rd_val_en && in_read;
      if (rd_val_en && in_read) begin
        fifo_wr_data <= rd_val_data;
      end
    end
  end

  // Saturates one past a full sector so an overlong sector still miscompares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      word_cnt <= '0;
    end else if (rd_val_en && in_read && (word_cnt != WCW'(SEC_WORDS + 1))) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stop_pend   <= 1'b0;
      tmo_cnt     <= '0;
      rd_start_en <= 1'b0;
      rd_sec_addr <= '0;
      sec_left    <= '0;
      stream_done <= 1'b0;
      error_flag  <= 1'b0;
    end else begin
      rd_start_en <= 1'b0;
      stream_done <= 1'b0;
      if (play_stop && (state != ST_IDLE) && (state != ST_DONE)) begin
        stop_pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            rd_sec_addr <= start_sec;
            sec_left    <= sec_num;
            error_flag  <= 1'b0;
            stop_pend   <= play_stop;
            state       <= (sec_num == 32'd0) ? ST_DONE : ST_WAIT_ROOM;
          end
        end

        ST_WAIT_ROOM: begin
          if (stop_req) begin
            state <= ST_DONE;
          end else if (room_ok) begin
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          rd_start_en <= 1'b1;
          tmo_cnt     <= '0;
          state       <= ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          if (rd_busy) begin
            state <= ST_WAIT_LO;
          end else if (tmo_cnt == TCW'(BUSY_TMO - 1)) begin
            error_flag <= 1'b1;
            state      <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        // A started sector always runs to completion, even with a stop pending.
        ST_WAIT_LO: begin
          if (busy_fall) begin
            if (word_cnt != WCW'(SEC_WORDS)) begin
              error_flag <= 1'b1;
            end
            rd_sec_addr <= rd_sec_addr + 33'd1;
            sec_left    <= sec_left - 32'd1;
            state       <= ((sec_left == 32'd1) || stop_req) ? ST_DONE : ST_WAIT_ROOM;
          end
        end

        ST_DONE: begin
          stream_done <= 1'b1;
          stop_pend   <= 1'b0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Directed bench for sd_stream_ctrl with a behavioural SD read model and an output monitor.
module tb_sd_stream_ctrl;
  import sd_stream_ctrl_pkg::*;

  localparam int SEC_WORDS = 256;
  localparam int FIFO_AW   = 10;
  localparam int BUSY_TMO  = 64;
  localparam int NV        = 7;

  typedef struct {
    logic [32:0] ssec;
    logic [31:0] num;
    int          usedw;
    int          short_k;
    int          stop_k;
    logic        with_stop;
    int          exp_starts;
    int          exp_wr;
    logic        exp_err;
    int          exp_left;
    logic [32:0] exp_addr;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sd_init_done;
  logic               play_start;
  logic               play_stop;
  logic [32:0]        start_sec;
  logic [31:0]        sec_num;
  logic               rd_busy;
  logic               rd_val_en;
  logic [15:0]        rd_val_data;
  logic               rd_start_en;
  logic [32:0]        rd_sec_addr;
  logic               fifo_full;
  logic [FIFO_AW-1:0] fifo_wrusedw;
  logic               fifo_wr_en;
  logic [15:0]        fifo_wr_data;
  logic               stream_busy;
  logic               stream_done;
  logic [31:0]        sec_left;
  logic               error_flag;

  always #5 clk = ~clk;

  sd_stream_ctrl #(
    .SEC_WORDS(SEC_WORDS),
    .FIFO_AW  (FIFO_AW),
    .BUSY_TMO (BUSY_TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sd_init_done(sd_init_done),
    .play_start  (play_start),
    .play_stop   (play_stop),
    .start_sec   (start_sec),
    .sec_num     (sec_num),
    .rd_busy     (rd_busy),
    .rd_val_en   (rd_val_en),
    .rd_val_data (rd_val_data),
    .rd_start_en (rd_start_en),
    .rd_sec_addr (rd_sec_addr),
    .fifo_full   (fifo_full),
    .fifo_wrusedw(fifo_wrusedw),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .stream_busy (stream_busy),
    .stream_done (stream_done),
    .sec_left    (sec_left),
    .error_flag  (error_flag)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every read start, FIFO write and done pulse seen with reset released.
  int          n_starts = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          data_err = 0;
  int          last_fall = 0;
  int          done_cyc = 0;
  logic        busy_q = 1'b0;
  logic [15:0] exp_data = 16'd0;
  logic [32:0] addr_log [256];
  int          start_cyc_log [256];
  int          gap_log [256];

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_q && !rd_busy) last_fall = cyc;
      if (rd_start_en) begin
        if (n_starts < 256) begin
          addr_log[n_starts]      = rd_sec_addr;
          start_cyc_log[n_starts] = cyc;
          gap_log[n_starts]       = cyc - last_fall;
        end
        n_starts++;
      end
      if (fifo_wr_en) begin
        if (fifo_wr_data !== exp_data) data_err++;
        exp_data = exp_data + 16'd1;
        n_wr++;
      end
      if (stream_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    busy_q = rd_busy;
  end

  // SD read model: busy two cycles after the start pulse, then a run of sequential words.
  logic        model_on = 1'b1;
  int          short_at = -1;
  int          m_cnt = 0;
  logic        m_active = 1'b0;
  logic [15:0] mdata = 16'd0;

  initial begin : sd_model
    int idx;
    int nw;
    rd_busy = 1'b0;
    rd_val_en = 1'b0;
    rd_val_data = 16'd0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_start_en) begin
        idx = m_cnt;
        m_cnt++;
        if (model_on) begin
          m_active = 1'b1;
          nw = (idx == short_at) ? SEC_WORDS - 1 : SEC_WORDS;
          repeat (2) @(posedge clk);
          #1 rd_busy = 1'b1;
          for (int i = 0; i < nw; i++) begin
            @(posedge clk);
            #1 rd_val_en = 1'b1;
            rd_val_data = mdata;
            mdata = mdata + 16'd1;
          end
          @(posedge clk);
          #1 rd_val_en = 1'b0;
          repeat (2) @(posedge clk);
          #1 rd_busy = 1'b0;
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, {31'd0, rd_sec_addr}, 64'd0);
    check({tag, "_left"}, {32'd0, sec_left}, 64'd0);
    check({tag, "_ctl"}, {43'd0, rd_start_en, fifo_wr_en, fifo_wr_data, stream_busy,
                          stream_done, error_flag}, 64'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [32:0] s, input logic [31:0] n, input logic stop,
                          output int c0);
    @(posedge clk);
    #1;
    start_sec  = s;
    sec_num    = n;
    play_start = 1'b1;
    play_stop  = stop;
    c0         = cyc;
    @(posedge clk);
    #1;
    play_start = 1'b0;
    play_stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1 play_stop = 1'b1;
    @(posedge clk);
    #1 play_stop = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (n_done > base) ok = 1'b1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (n_starts >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_model_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (!m_active) ok = 1'b1;
    end
    check("model_idle", ok, 1);
    tick(4);
  endtask

  initial begin : main
    vec_t        v [NV];
    int          b_st, b_wr, b_dn, c0, c1, d;
    bit          ok;
    logic [32:0] a;

    v[0] = '{ssec:33'd2000, num:32'd3, usedw:0, short_k:-1, stop_k:-1, with_stop:1'b0,
             exp_starts:3, exp_wr:768, exp_err:1'b0, exp_left:0, exp_addr:33'd2003};
    v[1] = '{ssec:33'd100, num:32'd5, usedw:0, short_k:-1, stop_k:0, with_stop:1'b0,
             exp_starts:1, exp_wr:256, exp_err:1'b0, exp_left:4, exp_addr:33'd101};
    v[2] = '{ssec:33'd7, num:32'd2, usedw:0, short_k:1, stop_k:-1, with_stop:1'b0,
             exp_starts:2, exp_wr:511, exp_err:1'b1, exp_left:0, exp_addr:33'd9};
    v[3] = '{ssec:33'h1_FFFF_FFFF, num:32'd2, usedw:0, short_k:-1, stop_k:-1, with_stop:1'b0,
             exp_starts:2, exp_wr:512, exp_err:1'b0, exp_left:0, exp_addr:33'd1};
    v[4] = '{ssec:33'd300, num:32'd4, usedw:0, short_k:-1, stop_k:-1, with_stop:1'b1,
             exp_starts:0, exp_wr:0, exp_err:1'b0, exp_left:4, exp_addr:33'd300};
    v[5] = '{ssec:33'd40, num:32'd1, usedw:768, short_k:-1, stop_k:-1, with_stop:1'b0,
             exp_starts:1, exp_wr:256, exp_err:1'b0, exp_left:0, exp_addr:33'd41};
    v[6] = '{ssec:33'd0, num:32'd1, usedw:0, short_k:-1, stop_k:-1, with_stop:1'b0,
             exp_starts:1, exp_wr:256, exp_err:1'b0, exp_left:0, exp_addr:33'd1};

    rst_n        = 1'b0;
    sd_init_done = 1'b1;
    play_start   = 1'b0;
    play_stop    = 1'b0;
    start_sec    = '0;
    sec_num      = '0;
    fifo_full    = 1'b0;
    fifo_wrusedw = '0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    for (int k = 0; k < NV; k++) begin
      b_st = n_starts;
      b_wr = n_wr;
      b_dn = n_done;
      fifo_wrusedw = FIFO_AW'(v[k].usedw);
      short_at = (v[k].short_k >= 0) ? b_st + v[k].short_k : -1;
      do_start(v[k].ssec, v[k].num, v[k].with_stop, c0);
      check("busy_after_start", stream_busy, 1);
      check("err_cleared_on_start", error_flag, 0);
      if (v[k].stop_k >= 0) begin
        wait_starts(b_st + v[k].stop_k + 1, 400, ok);
        check("stop_sector_started", ok, 1);
        tick(60);
        pulse_stop();
      end
      wait_done(b_dn, 3000, ok);
      check("done_seen", ok, 1);
      wait_model_idle();
      check("read_count", n_starts - b_st, v[k].exp_starts);
      check("write_count", n_wr - b_wr, v[k].exp_wr);
      check("done_pulses", n_done - b_dn, 1);
      check("error_flag", error_flag, v[k].exp_err);
      check("sec_left", sec_left, v[k].exp_left);
      check("final_addr", rd_sec_addr, v[k].exp_addr);
      check("busy_after_done", stream_busy, 0);
      if (v[k].exp_starts > 0) check("start_latency", start_cyc_log[b_st] - c0, 3);
      if (v[k].exp_starts > 1) check("fall_to_start", gap_log[b_st + 1], 3);
      for (int i = 0; i < v[k].exp_starts; i++) begin
        a = v[k].ssec + 33'(i);
        check("read_addr", addr_log[b_st + i], a);
      end
    end
    short_at = -1;

    // Room gating: 124 words free blocks the read until usedw drops to 768.
    b_st = n_starts;
    b_dn = n_done;
    fifo_wrusedw = 10'd900;
    do_start(33'd500, 32'd1, 1'b0, c0);
    tick(20);
    check("room_blocks_read", n_starts - b_st, 0);
    fifo_wrusedw = 10'd768;
    c1 = cyc;
    wait_starts(b_st + 1, 10, ok);
    check("room_read_seen", ok, 1);
    check("room_latency", start_cyc_log[b_st] - c1, 2);
    check("room_addr", addr_log[b_st], 500);
    wait_done(b_dn, 600, ok);
    check("room_done", ok, 1);
    wait_model_idle();
    fifo_wrusedw = '0;

    // FIFO full (usedw wrapped to 0): no read, and a stop exits from the room wait.
    b_st = n_starts;
    b_dn = n_done;
    fifo_full = 1'b1;
    do_start(33'd10, 32'd3, 1'b0, c0);
    tick(20);
    check("full_blocks_read", n_starts - b_st, 0);
    pulse_stop();
    wait_done(b_dn, 20, ok);
    check("full_stop_done", ok, 1);
    check("full_sec_left", sec_left, 3);
    check("full_addr", rd_sec_addr, 10);
    fifo_full = 1'b0;
    tick(2);

    // rd_busy never rises: timeout error after BUSY_TMO cycles.
    model_on = 1'b0;
    b_st = n_starts;
    b_dn = n_done;
    do_start(33'd42, 32'd2, 1'b0, c0);
    wait_starts(b_st + 1, 10, ok);
    check("tmo_read_seen", ok, 1);
    wait_done(b_dn, BUSY_TMO + 40, ok);
    check("tmo_done", ok, 1);
    check("tmo_error", error_flag, 1);
    d = done_cyc - start_cyc_log[b_st];
    check("tmo_window", (d >= BUSY_TMO) && (d <= BUSY_TMO + 2), 1);
    check("tmo_sec_left", sec_left, 2);
    model_on = 1'b1;
    tick(4);

    // sec_num = 0: done two cycles after the start, no reads.
    b_st = n_starts;
    b_dn = n_done;
    do_start(33'd5, 32'd0, 1'b0, c0);
    check("zero_err_cleared", error_flag, 0);
    wait_done(b_dn, 10, ok);
    check("zero_done", ok, 1);
    check("zero_done_cycle", done_cyc - c0, 2);
    check("zero_no_reads", n_starts - b_st, 0);
    tick(2);

    // Start refused while uninitialised; a stop in IDLE leaves nothing pending.
    b_st = n_starts;
    b_wr = n_wr;
    b_dn = n_done;
    sd_init_done = 1'b0;
    do_start(33'd3, 32'd1, 1'b0, c0);
    check("noinit_busy", stream_busy, 0);
    tick(3);
    check("noinit_no_reads", n_starts - b_st, 0);
    sd_init_done = 1'b1;
    pulse_stop();
    tick(2);
    do_start(33'd3, 32'd1, 1'b0, c0);
    wait_done(b_dn, 600, ok);
    check("idle_stop_done", ok, 1);
    wait_model_idle();
    check("idle_stop_reads", n_starts - b_st, 1);
    check("idle_stop_writes", n_wr - b_wr, 256);
    check("data_sequence_errors", data_err, 0);

    // Reset while words stream in WAIT_LO.
    b_wr = n_wr;
    do_start(33'd77, 32'd2, 1'b0, c0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (n_wr >= b_wr + 20) ok = 1'b1;
    end
    check("rst_mid_reached", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    tick(2);
    rst_n = 1'b1;
    b_wr = n_wr;
    wait_model_idle();
    check("rst_no_writes_after", n_wr - b_wr, 0);
    check_zero("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_stream_ctrl.md
# sd_stream_ctrl

Multi-sector read scheduler between the SD card controller's read port and the audio sample FIFO. On a play command, it issues consecutive single-sector reads starting at a given sector. A new read is issued only when the FIFO has room for a full sector. Read words are forwarded into the FIFO, the per-sector word count is checked, and the block reports completion or error to the player control logic.

## Interface
- `SEC_WORDS`, default 256: 16-bit words per sector (512 bytes).
- `FIFO_AW`, default 10: FIFO usedw width; FIFO depth = 2^FIFO_AW words.
- `BUSY_TMO`, default 4096: cycles allowed from `rd_start_en` to `rd_busy` high before an error is flagged.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, shared with the SD controller and the FIFO write side.
- `rst_n` in 1: asynchronous, active-low reset.
- `sd_init_done` in 1: SD card initialised; plays are refused while low.
- `play_start` in 1: one-cycle pulse; accepted only in IDLE.
- `play_stop` in 1: one-cycle pulse; stop request.
- `start_sec` in 33: first sector address; latched on an accepted `play_start`.
- `sec_num` in 32: number of sectors to read; latched on an accepted `play_start`.
- `rd_busy` in 1: SD read busy.
- `rd_val_en` in 1: read data valid.
- `rd_val_data` in 16: read data word.
- `rd_start_en` out 1: one-cycle read start pulse to the SD controller.
- `rd_sec_addr` out 33: sector address; stable from `rd_start_en` until `rd_busy` falls.
- `fifo_full` in 1: FIFO full.
- `fifo_wrusedw` in FIFO_AW: FIFO used words; wraps to 0 when full.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out 16: FIFO write data.
- `stream_busy` out 1: high whenever the state is not IDLE.
- `stream_done` out 1: one-cycle pulse when all sectors are read or a stop completes.
- `sec_left` out 32: sectors still to be read.
- `error_flag` out 1: sticky; cleared by reset or by the next accepted `play_start`.

## Operation
- States:
  - **IDLE**
    - `play_start` && `sd_init_done` latches `start_sec` into `rd_sec_addr` and `sec_num` into `sec_left`, clears `error_flag`.
    - If `sec_num` = 0, go to DONE; otherwise go to WAIT_ROOM.
    - `play_start` while `sd_init_done` is low is ignored.
  - **WAIT_ROOM**
    - room = `fifo_full` ? 0 : 2^FIFO_AW − `fifo_wrusedw`.
    - If a stop is pending, go to DONE.
    - Else if room ≥ SEC_WORDS, go to ISSUE.
  - **ISSUE**: assert `rd_start_en` for exactly one cycle, clear the word counter and timeout counter, go to WAIT_HI.
  - **WAIT_HI**
    - `rd_busy` high: go to WAIT_LO.
    - Timeout counter reaches BUSY_TMO: set `error_flag`, go to DONE.
  - **WAIT_LO**: on the falling edge of `rd_busy` (registered `rd_busy_d0` && !`rd_busy`):
    - Word counter ≠ SEC_WORDS: set `error_flag`.
    - `rd_sec_addr` += 1 (33-bit wrap); `sec_left` −= 1.
    - If `sec_left` was 1, or a stop is pending: go to DONE. Otherwise go to WAIT_ROOM.
  - **DONE**: `stream_done` = 1 for one cycle, clear the stop-pending flag, go to IDLE.
- Stop handling:
  - `play_stop` in any state other than IDLE sets the stop-pending flag.
  - A sector read in progress is never aborted; its data is still forwarded.
  - `play_stop` in IDLE is ignored.
- `play_start` outside IDLE is ignored. If `play_start` and `play_stop` arrive in the same cycle in IDLE, the start is accepted and the stop is pending immediately, so zero sectors are read.
- Forwarding:
  - `rd_val_en` in WAIT_HI or WAIT_LO produces `fifo_wr_en` and `fifo_wr_data` registered one cycle later.
  - `rd_val_en` in any other state is dropped.
  - The word counter increments per valid word and saturates at SEC_WORDS+1.
- FIFO overflow is prevented by the room check only; the block never writes while `fifo_full` is high if the FIFO sink behaves.

## Timing
- Reset values: `rd_start_en` = 0, `rd_sec_addr` = 0, `fifo_wr_en` = 0, `fifo_wr_data` = 0, `stream_busy` = 0, `stream_done` = 0, `sec_left` = 0, `error_flag` = 0, state = IDLE.
- `play_start` (cycle 0) → `stream_busy` high in cycle 1 → `rd_start_en` in cycle 3, given FIFO room.
- `rd_val_en` → `fifo_wr_en`: 1 cycle.
- Falling edge of `rd_busy` → next `rd_start_en`: at least 3 cycles (WAIT_LO → WAIT_ROOM → ISSUE).
- Reset mid-operation returns to IDLE immediately with all outputs at reset values; the SD controller is not notified.

## Structure
- Shared package holds:
  - state encoding (IDLE, WAIT_ROOM, ISSUE, WAIT_HI, WAIT_LO, DONE);
  - SD sector size constant (512 bytes / 256 words), shared with the SD write-side sequencer.
- Single module, no sub-modules; `rd_busy` edge detection is inline.

## Test plan
- `sec_num` = 3, `start_sec` = 2000, empty FIFO, model gives 256 words per sector: `rd_sec_addr` 2000, 2001, 2002 in sequence; 768 FIFO writes; one `stream_done`; `error_flag` = 0.
- FIFO `fifo_wrusedw` = 900 (room 124): no `rd_start_en`; drop `fifo_wrusedw` to 768 → `rd_start_en` follows within 2 cycles.
- `play_stop` mid-sector 1 of 5: sector completes with 256 words, no further `rd_start_en`, `stream_done` pulses, `sec_left` = 4.
- Model returns 255 words for a sector: `error_flag` sets at `rd_busy` fall and stays set; the next `play_start` clears it.
- `rd_busy` never rises: `error_flag` = 1 and `stream_done` after BUSY_TMO cycles.
- `sec_num` = 0 → `stream_done` after 2 cycles, no reads; `rst_n` low during WAIT_LO → all outputs return to 0.
